// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader writing big-endian words to memory; optional trailing XOR checksum under PROG_LOADER_CHECKSUM_EN
module prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_written
);
  localparam int CNT_W = 11;
  localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(1) << ADDR_W;
  typedef enum logic [3:0] {IDLE, CNT_H, CNT_L, ADR_H, ADR_L, D_H, D_L,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR} state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t LAST = CHK;
`else
  localparam state_t LAST = DONE;
`endif
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [7:0] hi_q, hi_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic we_q, we_d, cpu_q, cpu_d;
  logic [ADDR_W:0] words_q, words_d;
  logic acc;
  logic [15:0] adr_full;
  logic [ADDR_W+1:0] n_w, end_sum;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  assign rx_ready = !(state_q inside {DONE, ERR});
  assign acc = rx_valid && rx_ready;
  assign adr_full = {hi_q, rx_data};
  assign n_w = (ADDR_W+2)'(cnt_q);
  assign end_sum = (ADDR_W+2)'(adr_full[ADDR_W-1:0]) + n_w;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we = we_q;
  assign cpu_reset = cpu_q;
  assign load_done = state_q == DONE;
  assign load_err = state_q == ERR;
  assign words_written = words_q;
  // frame parser: header capture and check, word assembly and write issue, re-arm
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    base_d = base_q;
    idx_d = idx_q;
    hi_d = hi_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    words_d = words_q;
    cpu_d = state_q == DONE && !load_req;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d = csum_q;
    if (acc) csum_d = state_q == IDLE ? 8'h00 : csum_q ^ rx_data;
`endif
    if (acc) begin
      case (state_q)
        IDLE: state_d = rx_data == SYNC_BYTE ? CNT_H : IDLE;
        CNT_H: begin
          hi_d = rx_data;
          state_d = CNT_L;
        end
        CNT_L: begin
          cnt_d = {hi_q[2:0], rx_data};
          state_d = ADR_H;
        end
        ADR_H: begin
          hi_d = rx_data;
          state_d = ADR_L;
        end
        ADR_L: begin
          base_d = adr_full[ADDR_W-1:0];
          idx_d = '0;
          state_d = (cnt_q == '0 || n_w > DEPTH || end_sum > DEPTH) ? ERR : D_H;
        end
        D_H: begin
          hi_d = rx_data;
          state_d = D_L;
        end
        D_L: begin
          we_d = 1'b1;
          addr_d = base_q + idx_q[ADDR_W-1:0];
          wdata_d = {hi_q, rx_data};
          words_d = words_q + 1'b1;
          idx_d = idx_q + 1'b1;
          state_d = idx_q + 1'b1 == cnt_q ? LAST : D_H;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: state_d = rx_data == csum_q ? DONE : ERR;
`endif
        default: ;
      endcase
    end
    if (state_q inside {DONE, ERR} && load_req) begin
      state_d = IDLE;
      words_d = '0;
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      idx_q <= '0;
      hi_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      words_q <= '0;
      cpu_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      idx_q <= idx_d;
      hi_q <= hi_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      words_q <= words_d;
      cpu_q <= cpu_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader; checksum steps follow PROG_LOADER_CHECKSUM_EN
module tb_prog_loader;
  logic clk = 1'b0;
  logic reset, rx_valid, load_req, rx_ready, mem_we, cpu_reset, load_done, load_err;
  logic [7:0] rx_data;
  logic [9:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [10:0] words_written;
  int tests = 0, fails = 0, nw = 0, dup = 0, base_nw;
  logic [9:0] wa [64];
  logic [15:0] wd [64];
  logic prev_we = 1'b0;
  logic [9:0] prev_a = '0;
  logic [7:0] ck = '0;
  bit gap = 1'b0;

  prog_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .load_req(load_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  // write logger sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (mem_we) begin
      wa[nw % 64] = mem_addr;
      wd[nw % 64] = mem_wdata;
      if (prev_we && prev_a == mem_addr) dup++;
      nw++;
    end
    prev_we = mem_we;
    prev_a = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    ck ^= b;
    if (gap) @(negedge clk);
  endtask

  task automatic hdr(input logic [15:0] n, input logic [15:0] b);
    send(8'hA5);
    ck = 8'h00;
    send(n[15:8]);
    send(n[7:0]);
    send(b[15:8]);
    send(b[7:0]);
  endtask

  task automatic word(input logic [15:0] w);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic finish_ck();
`ifdef PROG_LOADER_CHECKSUM_EN
    send(ck);
`endif
  endtask

  task automatic end_frame(input string tag);
    check({tag, "_done"}, 32'(load_done), 32'd1);
    check({tag, "_cpu_hold"}, 32'(cpu_reset), 32'd0);
`ifndef PROG_LOADER_CHECKSUM_EN
    check({tag, "_last_we"}, 32'(mem_we), 32'd1);
`endif
    @(negedge clk);
    check({tag, "_cpu_release"}, 32'(cpu_reset), 32'd1);
    check({tag, "_we_low"}, 32'(mem_we), 32'd0);
  endtask

  task automatic chk_w(input string tag, input int k, input logic [9:0] a, input logic [15:0] d);
    check({tag, "_addr"}, 32'(wa[k % 64]), 32'(a));
    check({tag, "_data"}, 32'(wd[k % 64]), 32'(d));
  endtask

  task automatic rearm();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("rearm_done", 32'(load_done), 32'd0);
    check("rearm_err", 32'(load_err), 32'd0);
    check("rearm_words", 32'(words_written), 32'd0);
    check("rearm_cpu", 32'(cpu_reset), 32'd0);
    check("rearm_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_cpu"}, 32'(cpu_reset), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_err"}, 32'(load_err), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    // basic two-word frame to 0x010
    base_nw = nw;
    hdr(16'h0002, 16'h0010);
    word(16'h1234);
    word(16'hABCD);
    finish_ck();
    check("f1_words", 32'(words_written), 32'd2);
    end_frame("f1");
    check("f1_nw", 32'(nw - base_nw), 32'd2);
    chk_w("f1_w0", base_nw, 10'h010, 16'h1234);
    chk_w("f1_w1", base_nw + 1, 10'h011, 16'hABCD);
    check("f1_ready", 32'(rx_ready), 32'd0);
    // bytes offered while not ready are not consumed
    rx_data = 8'hA5;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    check("stall_done", 32'(load_done), 32'd1);
    check("stall_nw", 32'(nw - base_nw), 32'd2);
    rearm();
    // leading junk, then one word at 0x000
    base_nw = nw;
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    check("junk_nw", 32'(nw - base_nw), 32'd0);
    hdr(16'h0001, 16'h0000);
    word(16'hA55A);
    finish_ck();
    end_frame("junk");
    check("junk_nw2", 32'(nw - base_nw), 32'd1);
    chk_w("junk_w0", base_nw, 10'h000, 16'hA55A);
    check("junk_words", 32'(words_written), 32'd1);
    rearm();
    // header overruns memory: 2 words at 0x3FF
    base_nw = nw;
    hdr(16'h0002, 16'h03FF);
    check("ovf_err", 32'(load_err), 32'd1);
    check("ovf_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("ovf_cpu", 32'(cpu_reset), 32'd0);
    check("ovf_nw", 32'(nw - base_nw), 32'd0);
    rearm();
    // zero word count
    hdr(16'hF800, 16'h0000);
    check("zero_err", 32'(load_err), 32'd1);
    check("zero_nw", 32'(nw - base_nw), 32'd0);
    rearm();
    // exact fit at the top word; upper CNT_H bits ignored
    hdr(16'hF801, 16'h03FF);
    word(16'h0F0F);
    finish_ck();
    end_frame("top");
    check("top_nw", 32'(nw - base_nw), 32'd1);
    chk_w("top_w0", base_nw, 10'h3FF, 16'h0F0F);
    rearm();
`ifdef PROG_LOADER_CHECKSUM_EN
    // corrupted checksum, then a clean retry
    base_nw = nw;
    hdr(16'h0002, 16'h0010);
    word(16'h1234);
    word(16'hABCD);
    check("ck_value", 32'(ck), 32'h52);
    send(~ck);
    check("ckbad_err", 32'(load_err), 32'd1);
    @(negedge clk);
    check("ckbad_cpu", 32'(cpu_reset), 32'd0);
    check("ckbad_nw", 32'(nw - base_nw), 32'd2);
    rearm();
    hdr(16'h0002, 16'h0010);
    word(16'h1234);
    word(16'hABCD);
    finish_ck();
    end_frame("ckgood");
    check("ckgood_nw", 32'(nw - base_nw), 32'd4);
    rearm();
`endif
    // valid toggling every cycle during the frame
    base_nw = nw;
    gap = 1'b1;
    hdr(16'h0002, 16'h0020);
    word(16'h1234);
    send(8'hAB);
    gap = 1'b0;
    send(8'hCD);
    finish_ck();
    @(negedge clk);
    check("gap_done", 32'(load_done), 32'd1);
    check("gap_cpu", 32'(cpu_reset), 32'd1);
    check("gap_nw", 32'(nw - base_nw), 32'd2);
    chk_w("gap_w0", base_nw, 10'h020, 16'h1234);
    chk_w("gap_w1", base_nw + 1, 10'h021, 16'hABCD);
    rearm();
    // reset after the first high data byte
    base_nw = nw;
    hdr(16'h0003, 16'h0100);
    send(8'h77);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b0;
    @(negedge clk);
    check("midrst_nw", 32'(nw - base_nw), 32'd0);
    // loader restarts from IDLE
    hdr(16'h0001, 16'h0005);
    word(16'hBEEF);
    finish_ck();
    end_frame("after");
    check("after_nw", 32'(nw - base_nw), 32'd1);
    chk_w("after_w0", base_nw, 10'h005, 16'hBEEF);
    check("no_dup_we", 32'(dup), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
